// File: rtl/vector_result_packer_pkg.sv
// Shared types and helpers for vector_result_packer: element-width encodings,
// collection FSM states, and vector-length arithmetic.
`ifndef ONE_BYTE
`define ONE_BYTE   3'b000
`endif
`ifndef TWO_BYTE
`define TWO_BYTE   3'b001
`endif
`ifndef FOUR_BYTE
`define FOUR_BYTE  3'b010
`endif
`ifndef EIGHT_BYTE
`define EIGHT_BYTE 3'b011
`endif

package vector_result_packer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam int LONGEST_LEN_DEF = 64;
    localparam int VECTOR_SIZE_DEF = 8;
    localparam int VLEN_BITS_DEF   = LONGEST_LEN_DEF * VECTOR_SIZE_DEF;

    function automatic int vlen_bits(input int longest_len, input int vector_size);
        return longest_len * vector_size;
    endfunction

    // Encodings above EIGHT_BYTE are not defined; they collapse to 64-bit elements.
    function automatic logic [2:0] legal_vsew(input logic [2:0] vsew);
        return (vsew > `EIGHT_BYTE) ? `EIGHT_BYTE : vsew;
    endfunction

    function automatic int vlmax(input int vlen, input logic [2:0] vsew, input logic is_mask);
        if (is_mask) return vlen / 8;
        return vlen / (8 << legal_vsew(vsew));
    endfunction

endpackage

// File: rtl/vector_result_packer_element_merge.sv
// Combinational merge of one lane value into the register image at a given
// element index (SEW-wide field, or a single bit in mask mode).
module vector_element_merge
    import vector_result_packer_pkg::*;
#(
    parameter int VLEN_BITS   = 512,
    parameter int LONGEST_LEN = 64,
    parameter int IDX_W       = 9
) (
    input  logic [VLEN_BITS-1:0]   image_in,
    input  logic [IDX_W-1:0]       idx,
    input  logic [2:0]             sew,
    input  logic                   mask_mode,
    input  logic [LONGEST_LEN-1:0] value,
    input  logic                   we,
    output logic [VLEN_BITS-1:0]   image_out
);
    localparam int SH_W = IDX_W + 6;

    logic [VLEN_BITS-1:0] field_mask;
    logic [VLEN_BITS-1:0] field_val;
    logic [SH_W-1:0]      shift;

    always_comb begin
        field_mask = '0;
        shift      = '0;
        if (mask_mode) begin
            field_mask = VLEN_BITS'(1'b1);
            shift      = SH_W'(idx);
        end else begin
            case (sew)
                `ONE_BYTE:  field_mask = VLEN_BITS'(8'hFF);
                `TWO_BYTE:  field_mask = VLEN_BITS'(16'hFFFF);
                `FOUR_BYTE: field_mask = VLEN_BITS'(32'hFFFF_FFFF);
                default:    field_mask = VLEN_BITS'(64'hFFFF_FFFF_FFFF_FFFF);
            endcase
            shift = SH_W'(idx) << (3'd3 + sew);
        end
        // Result bits above SEW are dropped by the field mask.
        field_val = VLEN_BITS'(value) & field_mask;
        image_out = image_in;
        if (we) begin
            image_out = (image_in & ~(field_mask << shift)) | (field_val << shift);
        end
    end

endmodule

// File: rtl/vector_result_packer.sv
// Collects per-lane ALU results into one vector register image with v0 masking and
// tail handling. Define VECTOR_PACKER_TAIL_AGNOSTIC_EN to fill tail elements with ones.
module vector_result_packer
    import vector_result_packer_pkg::*;
#(
    parameter int LONGEST_LEN = 64,
    parameter int VECTOR_SIZE = 8,
    parameter int LANE_NUM    = 2,
    parameter int DATA_LEN    = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [2:0]                      vsew,
    input  logic [DATA_LEN-1:0]             vl,
    input  logic                            vm,
    input  logic                            is_mask_operation,
    input  logic [VECTOR_SIZE*LONGEST_LEN-1:0] v0_mask,
    input  logic [VECTOR_SIZE*LONGEST_LEN-1:0] old_vd,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [LANE_NUM*LONGEST_LEN-1:0] lane_result,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [VECTOR_SIZE*LONGEST_LEN-1:0] out_data,
    output logic                            busy,
    output logic [1:0]                      state_dbg
);
    localparam int VLEN_BITS = VECTOR_SIZE * LONGEST_LEN;
    localparam int IDX_W     = $clog2(VLEN_BITS / 8) + 2;
    localparam int V0_W      = $clog2(VLEN_BITS);

    // Handshakes: a beat moves when in_valid && in_ready; the image is taken when
    // out_valid && out_ready. Both valids hold until their ready.
    state_t state, state_next;

    logic [IDX_W-1:0]     elem_idx;
    logic [IDX_W-1:0]     vl_eff;
    logic [2:0]           vsew_q;
    logic                 vm_q;
    logic                 mask_q;
    logic [VLEN_BITS-1:0] v0_q;
    logic [VLEN_BITS-1:0] image;

    logic [2:0]           vsew_start;
    int                   vlmax_start;
    logic [IDX_W-1:0]     vl_eff_start;
    logic [VLEN_BITS-1:0] start_image;
    logic                 start_ok;
    logic                 accept;
    logic                 last_beat;
    logic [IDX_W:0]       idx_sum;

    always_comb begin
        vsew_start  = legal_vsew(vsew);
        vlmax_start = vlmax(VLEN_BITS, vsew_start, is_mask_operation);
        if (64'(vl) < 64'(vlmax_start)) vl_eff_start = IDX_W'(vl);
        else                            vl_eff_start = IDX_W'(vlmax_start);
    end

`ifdef VECTOR_PACKER_TAIL_AGNOSTIC_EN
    logic [IDX_W+6:0] tail_bit;
    always_comb begin
        tail_bit = is_mask_operation ? (IDX_W+7)'(vl_eff_start)
                                     : (IDX_W+7)'(vl_eff_start) << (3'd3 + vsew_start);
        // VLMAX*SEW spans the whole register, so the tail is every bit from tail_bit up.
        start_image = old_vd | ({VLEN_BITS{1'b1}} << tail_bit);
    end
`else
    assign start_image = old_vd;
`endif

    assign start_ok  = (state == IDLE) && start;
    assign accept    = in_valid && in_ready;
    assign idx_sum   = (IDX_W+1)'(elem_idx) + (IDX_W+1)'(LANE_NUM);
    assign last_beat = accept && (idx_sum >= (IDX_W+1)'(vl_eff));

    logic [VLEN_BITS-1:0] chain [LANE_NUM+1];
    assign chain[0] = image;

    for (genvar k = 0; k < LANE_NUM; k++) begin : g_lane
        logic [IDX_W:0] e;
        logic           we;
        assign e  = (IDX_W+1)'(elem_idx) + (IDX_W+1)'(k);
        assign we = accept && (e < (IDX_W+1)'(vl_eff)) && (vm_q || v0_q[V0_W'(e)]);

        vector_element_merge #(
            .VLEN_BITS  (VLEN_BITS),
            .LONGEST_LEN(LONGEST_LEN),
            .IDX_W      (IDX_W + 1)
        ) u_merge (
            .image_in (chain[k]),
            .idx      (e),
            .sew      (vsew_q),
            .mask_mode(mask_q),
            .value    (lane_result[k*LONGEST_LEN +: LONGEST_LEN]),
            .we       (we),
            .image_out(chain[k+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) state_next = (vl_eff_start == '0) ? DONE : COLLECT;
            end
            COLLECT: begin
                in_ready = 1'b1;
                if (last_beat) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            elem_idx <= '0;
            vl_eff   <= '0;
            vsew_q   <= `ONE_BYTE;
            vm_q     <= 1'b0;
            mask_q   <= 1'b0;
            v0_q     <= '0;
            image    <= '0;
        end else if (start_ok) begin
            elem_idx <= '0;
            vl_eff   <= vl_eff_start;
            vsew_q   <= vsew_start;
            vm_q     <= vm;
            mask_q   <= is_mask_operation;
            v0_q     <= v0_mask;
            image    <= start_image;
        end else if (accept) begin
            image    <= chain[LANE_NUM];
            elem_idx <= idx_sum[IDX_W] ? {IDX_W{1'b1}} : idx_sum[IDX_W-1:0];
        end
    end

    assign out_data  = image;
    assign state_dbg = state;

endmodule

// File: tb/tb_vector_result_packer.sv
// Randomized self-checking bench for vector_result_packer against an element-level
// reference model of masking and tail policy.
module tb_vector_result_packer;
    import vector_result_packer_pkg::*;

    localparam int LL   = 64;
    localparam int VS   = 8;
    localparam int LN   = 2;
    localparam int DL   = 32;
    localparam int VLEN = LL * VS;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [2:0]        vsew;
    logic [DL-1:0]     vl;
    logic              vm;
    logic              is_mask_operation;
    logic [VLEN-1:0]   v0_mask;
    logic [VLEN-1:0]   old_vd;
    logic              in_valid;
    logic              in_ready;
    logic [LN*LL-1:0]  lane_result;
    logic              out_valid;
    logic              out_ready;
    logic [VLEN-1:0]   out_data;
    logic              busy;
    logic [1:0]        state_dbg;

    int checks = 0;
    int errors = 0;

    logic [63:0]     vals [0:71];
    logic [VLEN-1:0] last_out;

    vector_result_packer #(
        .LONGEST_LEN(LL), .VECTOR_SIZE(VS), .LANE_NUM(LN), .DATA_LEN(DL)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .vsew(vsew), .vl(vl), .vm(vm),
        .is_mask_operation(is_mask_operation), .v0_mask(v0_mask), .old_vd(old_vd),
        .in_valid(in_valid), .in_ready(in_ready), .lane_result(lane_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    function automatic int ref_vl_eff(input logic [2:0] vs, input logic [31:0] vl_in, input logic msk);
        int sew_bytes;
        int vmax;
        sew_bytes = (vs > 3'd3) ? 8 : (1 << vs);
        vmax = msk ? VLEN / 8 : VLEN / (8 * sew_bytes);
        return (vl_in < 32'(vmax)) ? int'(vl_in) : vmax;
    endfunction

    function automatic logic [VLEN-1:0] ref_image(input logic [VLEN-1:0] old, input logic [2:0] vs,
                                                  input logic [31:0] vl_in, input logic vm_in,
                                                  input logic msk, input logic [VLEN-1:0] v0);
        logic [VLEN-1:0] img;
        int sew;
        int vmax;
        int vle;
        sew  = msk ? 1 : 8 * ((vs > 3'd3) ? 8 : (1 << vs));
        vmax = VLEN / sew;
        if (msk) vmax = VLEN / 8;
        vle  = ref_vl_eff(vs, vl_in, msk);
        img  = old;
        for (int e = 0; e < vmax; e++) begin
            if (e < vle) begin
                if (vm_in || v0[e])
                    for (int b = 0; b < sew; b++) img[e*sew + b] = vals[e][b];
            end else begin
`ifdef VECTOR_PACKER_TAIL_AGNOSTIC_EN
                for (int b = 0; b < sew; b++) img[e*sew + b] = 1'b1;
`endif
            end
        end
        // Mask-mode bits beyond VLMAX are neither body nor tail elements of this op.
        if (msk) begin
`ifdef VECTOR_PACKER_TAIL_AGNOSTIC_EN
            for (int b = VLEN / 8; b < VLEN; b++) img[b] = 1'b1;
`endif
        end
        return img;
    endfunction

    function automatic logic [VLEN-1:0] rand_vec();
        logic [VLEN-1:0] v;
        for (int i = 0; i < VLEN / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic run_txn(input logic [VLEN-1:0] old, input logic [2:0] vs, input logic [31:0] vl_in,
                           input logic vm_in, input logic msk, input logic [VLEN-1:0] v0,
                           input int hold, input string name);
        logic [VLEN-1:0] exp;
        int vle, nbeats, beats, idx, guard;
        logic iv;
        exp    = ref_image(old, vs, vl_in, vm_in, msk, v0);
        vle    = ref_vl_eff(vs, vl_in, msk);
        nbeats = (vle + LN - 1) / LN;
        @(negedge clk);
        old_vd = old; vsew = vs; vl = vl_in; vm = vm_in; is_mask_operation = msk; v0_mask = v0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Scramble the instruction inputs: the packer must work from latched copies.
        old_vd = rand_vec(); v0_mask = rand_vec(); vsew = 3'($urandom_range(0, 7));
        vl = $urandom; vm = 1'($urandom); is_mask_operation = 1'($urandom);
        if (nbeats == 0) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s zero_vl_timing: out_valid=%b in_ready=%b, required 1 0", name, out_valid, in_ready);
            end
        end else begin
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s ready_after_start: in_ready=%b out_valid=%b, required 1 0", name, in_ready, out_valid);
            end
            beats = 0; idx = 0; guard = 0;
            while (beats < nbeats && guard < 2000) begin
                checks++;
                if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL %s collect_state beat %0d: out_valid=%b in_ready=%b, required 0 1", name, beats, out_valid, in_ready);
                end
                iv = ($urandom_range(0, 3) != 0);
                in_valid = iv;
                lane_result = {vals[idx+1], vals[idx]};
                @(negedge clk);
                in_valid = 1'b0;
                lane_result = {$urandom, $urandom, $urandom, $urandom};
                if (iv) begin
                    beats++;
                    idx += LN;
                end
                guard++;
            end
            if (guard >= 2000) begin
                checks++; errors++;
                $display("FAIL %s beat_timeout: beats=%0d, required %0d", name, beats, nbeats);
            end
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s done_timing: out_valid=%b in_ready=%b, required 1 0", name, out_valid, in_ready);
            end
        end
        checks++;
        if (out_data !== exp) begin
            errors++;
            $display("FAIL %s out_data: got %h", name, out_data);
            $display("FAIL %s out_data: exp %h", name, exp);
        end
        last_out = out_data;
        for (int h = 0; h < hold; h++) begin
            start = 1'($urandom_range(0, 1));
            vl = 32'($urandom_range(1, 20));
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== last_out) begin
                errors++;
                $display("FAIL %s hold_stable cycle %0d: out_valid=%b data_changed=%b, required 1 0", name, h, out_valid, out_data !== last_out);
            end
        end
        out_ready = 1'b1;
        start = (hold > 0);
        vl = 32'd4;
        @(negedge clk);
        out_ready = 1'b0;
        start = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s release_idle: out_valid=%b busy=%b in_ready=%b, required 0 0 0", name, out_valid, busy, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_values: in_ready=%b out_valid=%b busy=%b out_data_zero=%b, required 0 0 0 1", in_ready, out_valid, busy, out_data === '0);
        end
    endtask

    task automatic test_word_fill();
        for (int i = 0; i < 72; i++) vals[i] = {$urandom, $urandom};
        for (int i = 0; i < 16; i++) vals[i] = 64'(i + 1);
        run_txn('0, 3'd2, 32'd16, 1'b1, 1'b0, rand_vec(), 0, "word_fill");
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (last_out[i*32 +: 32] !== 32'(i + 1)) begin
                errors++;
                $display("FAIL word_fill word %0d: got %h, required %h", i, last_out[i*32 +: 32], 32'(i + 1));
            end
        end
    endtask

    task automatic test_masked_bytes();
        logic [7:0] exp_b [0:7];
        for (int i = 0; i < 72; i++) vals[i] = 64'h11;
        run_txn({(VLEN/8){8'hAA}}, 3'd0, 32'd5, 1'b0, 1'b0, VLEN'(5'b10101), 0, "masked_bytes");
        exp_b[0] = 8'h11; exp_b[1] = 8'hAA; exp_b[2] = 8'h11; exp_b[3] = 8'hAA; exp_b[4] = 8'h11;
`ifdef VECTOR_PACKER_TAIL_AGNOSTIC_EN
        exp_b[5] = 8'hFF; exp_b[6] = 8'hFF; exp_b[7] = 8'hFF;
`else
        exp_b[5] = 8'hAA; exp_b[6] = 8'hAA; exp_b[7] = 8'hAA;
`endif
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (last_out[i*8 +: 8] !== exp_b[i]) begin
                errors++;
                $display("FAIL masked_bytes byte %0d: got %h, required %h", i, last_out[i*8 +: 8], exp_b[i]);
            end
        end
    endtask

    task automatic test_mask_op();
        for (int i = 0; i < 72; i++) vals[i] = {$urandom, $urandom};
        vals[0] = 64'hFFFF_0001; vals[1] = 64'hFFFF_FFFE; vals[2] = 64'h0000_0003;
        run_txn('0, 3'd3, 32'd3, 1'b1, 1'b1, '0, 0, "mask_op");
        checks++;
`ifdef VECTOR_PACKER_TAIL_AGNOSTIC_EN
        if (last_out[7:0] !== 8'b1111_1101) begin
`else
        if (last_out[7:0] !== 8'b0000_0101) begin
`endif
            errors++;
            $display("FAIL mask_op low_bits: got %b", last_out[7:0]);
        end
    endtask

    task automatic test_vl_zero();
        logic [VLEN-1:0] pat;
        pat = {(VLEN/16){16'h1234}};
        run_txn(pat, 3'd1, 32'd0, 1'b1, 1'b0, '0, 0, "vl_zero");
        checks++;
`ifdef VECTOR_PACKER_TAIL_AGNOSTIC_EN
        if (last_out !== {VLEN{1'b1}}) begin
`else
        if (last_out !== pat) begin
`endif
            errors++;
            $display("FAIL vl_zero image: got %h", last_out);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 72; i++) vals[i] = {$urandom, $urandom};
        run_txn(rand_vec(), 3'd1, 32'd9, 1'b0, 1'b0, rand_vec(), 5, "backpressure");
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 72; i++) vals[i] = {$urandom, $urandom};
        @(negedge clk);
        old_vd = rand_vec(); vsew = 3'd3; vl = 32'd8; vm = 1'b1; is_mask_operation = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int b = 0; b < 2; b++) begin
            in_valid = 1'b1;
            lane_result = {vals[2*b+1], vals[2*b]};
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_mid: in_ready=%b out_valid=%b busy=%b out_data_zero=%b, required 0 0 0 1", in_ready, out_valid, busy, out_data === '0);
        end
        run_txn(rand_vec(), 3'd3, 32'd8, 1'b1, 1'b0, '0, 0, "after_reset");
    endtask

    task automatic test_random();
        logic [31:0] vl_r;
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < 72; i++) vals[i] = {$urandom, $urandom};
            vl_r = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 70));
            run_txn(rand_vec(), 3'($urandom_range(0, 7)), vl_r, 1'($urandom), 1'($urandom_range(0, 3) == 0),
                    rand_vec(), $urandom_range(0, 3), "random");
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; vsew = 3'd0; vl = '0; vm = 1'b0; is_mask_operation = 1'b0;
        v0_mask = '0; old_vd = '0; in_valid = 1'b0; lane_result = '0; out_ready = 1'b0;
        test_reset();
        test_word_fill();
        test_masked_bytes();
        test_mask_op();
        test_vl_zero();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
